// File: rtl/tcn_actmem_reader_if.sv
// Bus bundle for the activation-memory reader: burst command, SRAM bank port and
// output stream. Signal suffixes are relative to the reader (master side).
interface tcn_actmem_reader_if #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 80
);
    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic [ADDR_WIDTH-1:0] cmd_base_i;
    logic [ADDR_WIDTH:0]   cmd_len_i;

    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [DATA_WIDTH-1:0] mem_be_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [DATA_WIDTH-1:0] out_data_o;
    logic                  out_last_o;

    modport master (
        input  cmd_valid_i, cmd_base_i, cmd_len_i, mem_rdata_i, out_ready_i,
        output cmd_ready_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
        output out_valid_o, out_data_o, out_last_o
    );

    modport slave (
        output cmd_valid_i, cmd_base_i, cmd_len_i, mem_rdata_i, out_ready_i,
        input  cmd_ready_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
        input  out_valid_o, out_data_o, out_last_o
    );
endinterface

// File: rtl/tcn_actmem_reader.sv
// Burst read initiator for one TCN activation bank: circular-address reads into a
// credit-controlled capture FIFO, streamed out with backpressure.
// Optional stall statistics are built when TCN_ACTMEM_READER_STATS_EN is defined.
module tcn_actmem_reader #(
    parameter int NUM_WORDS  = 8,
    parameter int DATA_WIDTH = 80,
    parameter int FIFO_DEPTH = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    tcn_actmem_reader_if.master    bus,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [15:0]            stall_cnt_o
);
    localparam int ADDR_WIDTH = $clog2(NUM_WORDS);
    localparam int LEN_W      = ADDR_WIDTH + 1;
    localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [LEN_W-1:0]      issued_q, issued_d;
    logic [LEN_W-1:0]      popped_q, popped_d;
    logic                  done_q, done_d;
    logic                  inflight_q;
    logic [CNT_W-1:0]      fifo_cnt_q, fifo_cnt_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];

    logic cmd_accept, credit_ok, mem_req, push, pop, out_valid, head_is_last;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Credit counts words already captured plus the one returning this cycle, so a
    // request never outruns FIFO space; pops are ignored to keep ready off this path.
    assign credit_ok    = ({1'b0, fifo_cnt_q} + (CNT_W+1)'(inflight_q)) < (CNT_W+1)'(FIFO_DEPTH);
    assign cmd_accept   = (state_q == S_IDLE) && bus.cmd_valid_i;
    assign mem_req      = (state_q == S_READ) && (issued_q < len_q) && credit_ok;
    assign push         = inflight_q;
    assign out_valid    = (fifo_cnt_q != '0);
    assign pop          = out_valid && bus.out_ready_i;
    assign head_is_last = (popped_q + LEN_W'(1)) == len_q;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        len_d    = len_q;
        issued_d = issued_q;
        popped_d = popped_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_accept) begin
                    addr_d   = bus.cmd_base_i;
                    len_d    = bus.cmd_len_i;
                    issued_d = '0;
                    popped_d = '0;
                    if (bus.cmd_len_i != '0) state_d = S_READ;
                    else                     done_d  = 1'b1;
                end
            end
            S_READ: begin
                if (mem_req) begin
                    addr_d   = (addr_q == ADDR_WIDTH'(NUM_WORDS - 1)) ? '0 : addr_q + ADDR_WIDTH'(1);
                    issued_d = issued_q + LEN_W'(1);
                    if (issued_q + LEN_W'(1) == len_q) state_d = S_DRAIN;
                end
                if (pop) popped_d = popped_q + LEN_W'(1);
            end
            S_DRAIN: begin
                if (pop) begin
                    popped_d = popped_q + LEN_W'(1);
                    if (head_is_last) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            popped_q   <= '0;
            done_q     <= 1'b0;
            inflight_q <= 1'b0;
            fifo_cnt_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            popped_q   <= popped_d;
            done_q     <= done_d;
            inflight_q <= mem_req;
            fifo_cnt_q <= fifo_cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Storage carries data only; occupancy is tracked by the reset pointers.
    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr_q] <= bus.mem_rdata_i;
    end

`ifdef TCN_ACTMEM_READER_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (cmd_accept)
            stall_cnt_d = '0;
        else if (out_valid && !bus.out_ready_i && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) stall_cnt_q <= '0;
        else         stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = 16'h0;
`endif

    assign bus.cmd_ready_o = (state_q == S_IDLE);
    assign bus.mem_req_o   = mem_req;
    assign bus.mem_we_o    = 1'b0;
    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_wdata_o = '0;
    assign bus.mem_be_o    = '1;
    assign bus.out_valid_o = out_valid;
    assign bus.out_data_o  = out_valid ? fifo_mem[rd_ptr_q] : '0;
    assign bus.out_last_o  = out_valid && head_is_last;
    assign busy_o          = (state_q != S_IDLE);
    assign done_o          = done_q;
endmodule
